// File: rtl/div_pkg.sv
// div_pkg: op encodings, FSM states, width and most-negative constants for div_ctrl64
package div_pkg;
  localparam int XLEN = 64;
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;
  localparam logic [31:0] MIN32 = 32'h8000_0000;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_DONE, S_DRAIN} div_state_e;
  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction
  function automatic logic is_rem(input logic [1:0] op);
    return op == DIV_OP_REM || op == DIV_OP_REMU;
  endfunction
endpackage

// File: rtl/div_sign_fix64.sv
// div_sign_fix64: operand extension, magnitudes, special cases (op/w/src1/src2 in) and result sign fix (r_* and core_q/core_rem in, res out)
module div_sign_fix64 import div_pkg::*; (
  input  logic [1:0]  op,
  input  logic        w,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  output logic [63:0] abs_a,
  output logic [63:0] abs_b,
  output logic        neg_q,
  output logic        neg_r,
  output logic        special,
  output logic [63:0] spec_res,
  input  logic [1:0]  r_op,
  input  logic        r_w,
  input  logic        r_neg_q,
  input  logic        r_neg_r,
  input  logic [63:0] core_q,
  input  logic [63:0] core_rem,
  output logic [63:0] res
);
  logic sgn, div0, ovf;
  logic [63:0] a, b, spec_raw, q, r, raw;
  assign sgn = op == DIV_OP_DIV || op == DIV_OP_REM;
  assign a = w ? (sgn ? sext32(src1[31:0]) : {32'b0, src1[31:0]}) : src1;
  assign b = w ? (sgn ? sext32(src2[31:0]) : {32'b0, src2[31:0]}) : src2;
  assign div0 = b == '0;
  assign ovf = sgn && &b && a == (w ? sext32(MIN32) : MIN64);
  assign special = div0 | ovf;
  assign neg_q = sgn & (a[63] ^ b[63]);
  assign neg_r = sgn & a[63];
  assign abs_a = neg_r ? -a : a;
  assign abs_b = (sgn & b[63]) ? -b : b;
  assign spec_raw = is_rem(op) ? (div0 ? a : '0) : (div0 ? '1 : a);
  assign spec_res = w ? sext32(spec_raw[31:0]) : spec_raw;
  assign q = r_neg_q ? -core_q : core_q;
  assign r = r_neg_r ? -core_rem : core_rem;
  assign raw = is_rem(r_op) ? r : q;
  assign res = r_w ? sext32(raw[31:0]) : raw;
endmodule

// File: rtl/div_ctrl64.sv
// div_ctrl64: RISC-V M divide sequencer (req_* handshake in, resp_* out, core_* to/from SRT-4 core, flush kill, rstn async active-high)
module div_ctrl64 #(
  parameter int XLEN = div_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic            req_w,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            core_start,
  output logic [XLEN-1:0] core_dividend,
  output logic [XLEN-1:0] core_divisor,
  output logic            core_hold,
  input  logic            core_valid,
  input  logic [XLEN-1:0] core_q,
  input  logic [XLEN-1:0] core_rem
);
  import div_pkg::*;
  div_state_e state;
  logic [1:0] op_q;
  logic w_q, neg_q_q, neg_r_q, neg_q, neg_r, special;
  logic [XLEN-1:0] abs_a, abs_b, spec_res, res;
  assign core_hold = 1'b0;
  div_sign_fix64 u_fix (
    .op(req_op), .w(req_w), .src1(req_src1), .src2(req_src2),
    .abs_a(abs_a), .abs_b(abs_b), .neg_q(neg_q), .neg_r(neg_r),
    .special(special), .spec_res(spec_res),
    .r_op(op_q), .r_w(w_q), .r_neg_q(neg_q_q), .r_neg_r(neg_r_q),
    .core_q(core_q), .core_rem(core_rem), .res(res)
  );
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state <= S_IDLE;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_data <= '0;
      core_start <= 1'b0;
      core_dividend <= '0;
      core_divisor <= '0;
      op_q <= '0;
      w_q <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid && !flush) begin
          op_q <= req_op;
          w_q <= req_w;
          neg_q_q <= neg_q;
          neg_r_q <= neg_r;
          req_ready <= 1'b0;
          if (special) begin
            resp_data <= spec_res;
            resp_valid <= 1'b1;
            state <= S_DONE;
          end else begin
            core_dividend <= abs_a;
            core_divisor <= abs_b;
            core_start <= 1'b1;
            state <= S_START;
          end
        end
        S_START: begin
          core_start <= 1'b0;
          state <= flush ? S_DRAIN : S_WAIT;
        end
        S_WAIT: if (core_valid && flush) begin
          req_ready <= 1'b1;
          state <= S_IDLE;
        end else if (core_valid) begin
          resp_data <= res;
          resp_valid <= 1'b1;
          state <= S_DONE;
        end else if (flush) state <= S_DRAIN;
        S_DONE: if (resp_ready || flush) begin
          resp_valid <= 1'b0;
          req_ready <= 1'b1;
          state <= S_IDLE;
        end
        S_DRAIN: if (core_valid) begin
          req_ready <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_ctrl64.sv
// tb_div_ctrl64: directed self-checking bench for div_ctrl64 with a fixed-latency core model
module tb_div_ctrl64;
  import div_pkg::*;
  localparam int LAT = 3;
  logic clk = 1'b0, rstn = 1'b1;
  logic req_valid = 1'b0, req_ready, req_w = 1'b0, flush = 1'b0;
  logic resp_valid, resp_ready = 1'b0, core_start, core_hold, core_valid = 1'b0;
  logic [1:0] req_op = '0;
  logic [63:0] req_src1 = '0, req_src2 = '0, resp_data, core_dividend, core_divisor;
  logic [63:0] core_q = '0, core_rem = '0, cap_a = '0, cap_b = '0;
  int tests = 0, fails = 0, starts = 0;
  always #5 clk = ~clk;
  div_ctrl64 dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_w(req_w), .req_src1(req_src1), .req_src2(req_src2),
    .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .core_start(core_start), .core_dividend(core_dividend), .core_divisor(core_divisor),
    .core_hold(core_hold), .core_valid(core_valid), .core_q(core_q), .core_rem(core_rem)
  );
  initial forever begin
    @(negedge clk);
    if (core_start) begin
      cap_a = core_dividend;
      cap_b = core_divisor;
      starts++;
      repeat (LAT) @(negedge clk);
      core_q = cap_b == 0 ? '1 : cap_a / cap_b;
      core_rem = cap_b == 0 ? cap_a : cap_a % cap_b;
      core_valid = 1'b1;
      @(negedge clk);
      core_valid = 1'b0;
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_w = w;
    req_src1 = a;
    req_src2 = b;
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic run(input string tag, input logic [1:0] op, input logic w, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] exp, input int exp_starts,
                     input logic [63:0] da, input logic [63:0] db, input int hold);
    int s0, lat;
    s0 = starts;
    issue(op, w, a, b);
    lat = 0;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), exp_starts != 0 ? 64'(LAT + 1) : 64'd0);
    check({tag, "_data"}, resp_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_v"}, 64'(resp_valid), 64'd1);
      check({tag, "_hold_d"}, resp_data, exp);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_vlow"}, 64'(resp_valid), 64'd0);
    check({tag, "_rdy"}, 64'(req_ready), 64'd1);
    check({tag, "_starts"}, 64'(starts - s0), 64'(exp_starts));
    if (exp_starts != 0) begin
      check({tag, "_dvd"}, cap_a, da);
      check({tag, "_dvs"}, cap_b, db);
    end
  endtask
  initial begin
    int s0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_rvalid", 64'(resp_valid), 64'd0);
    check("rst_rdata", resp_data, 64'd0);
    check("rst_start", 64'(core_start), 64'd0);
    check("rst_dvd", core_dividend, 64'd0);
    check("rst_dvs", core_divisor, 64'd0);
    check("rst_hold", 64'(core_hold), 64'd0);
    rstn = 1'b0;
    run("divu", DIV_OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 1, 64'd100, 64'd7, 0);
    run("remu", DIV_OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 1, 64'd100, 64'd7, 0);
    run("div_neg", DIV_OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 1, 64'd100, 64'd7, 0);
    run("rem_neg", DIV_OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1, 64'd100, 64'd7, 0);
    run("div_z", DIV_OP_DIV, 1'b0, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
    run("remu_z", DIV_OP_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 0, 0, 0, 0);
    run("divw_ovf", DIV_OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0, 0, 0, 0);
    run("remw_ovf", DIV_OP_REM, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 0, 0, 0);
    run("div_ovf", DIV_OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0, 0, 0, 0);
    run("divw_neg", DIV_OP_DIV, 1'b1, 64'h1234_5678_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 1, 64'd100, 64'd7, 0);
    s0 = starts;
    issue(DIV_OP_DIVU, 1'b0, 64'd100, 64'd7);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("drain_state", 64'(dut.state), 64'(S_DRAIN));
    check("drain_ready0", 64'(req_ready), 64'd0);
    check("drain_rvalid0", 64'(resp_valid), 64'd0);
    @(negedge clk);
    check("drain_ready1", 64'(req_ready), 64'd0);
    check("drain_rvalid1", 64'(resp_valid), 64'd0);
    @(negedge clk);
    check("drain_done_ready", 64'(req_ready), 64'd1);
    check("drain_done_rvalid", 64'(resp_valid), 64'd0);
    check("drain_starts", 64'(starts - s0), 64'd1);
    run("after_drain", DIV_OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 1, 64'd100, 64'd7, 0);
    run("stall", DIV_OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 1, 64'd100, 64'd7, 5);
    issue(DIV_OP_DIVU, 1'b0, 64'd1000, 64'd10);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("arst_ready", 64'(req_ready), 64'd1);
    check("arst_rvalid", 64'(resp_valid), 64'd0);
    check("arst_rdata", resp_data, 64'd0);
    check("arst_start", 64'(core_start), 64'd0);
    check("arst_dvd", core_dividend, 64'd0);
    check("arst_dvs", core_divisor, 64'd0);
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_valid_rvalid", 64'(resp_valid), 64'd0);
    check("stray_valid_ready", 64'(req_ready), 64'd1);
    run("after_rst", DIV_OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 1, 64'd100, 64'd7, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
